sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of strobe-active cycles per access; legal range 1..15.
REQ-002 Parameter: ADDR_W, default 18, width of word address from the datapath; MSB is the bank select.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  1  access request from datapath; sampled only in IDLE.
REQ-006 Port: we  input  1  1 = write, 0 = read; latched with req.
REQ-007 Port: addr  input  ADDR_W  word address; addr[ADDR_W-1] selects bank, addr[ADDR_W-2:0] drives the chips.
REQ-008 Port: wdata  input  32  write data; latched with req.
REQ-009 Port: byte_mask  input  4  write byte enables, bit i = byte i; latched with req.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: ready  output  1  single-cycle completion pulse.
REQ-012 Port: rdata  output  32  registered read data.
REQ-013 Port: sram_cs_n  output  2  active-low chip select per bank, bit0 = bank 0 (both 16-bit chips of a bank share it).
REQ-014 Port: sram_oe_n, sram_we_n  output  1 each  active-low output/write strobes shared by all chips.
REQ-015 Port: sram_bl_n  output  4  active-low byte lanes: [0]/[1] = LB/UB of low chip, [2]/[3] = LB/UB of high chip.
REQ-016 Port: sram_addr  output  ADDR_W-1  chip address.
REQ-017 Port: sram_dq_o  output  32, sram_dq_oe  output  1, sram_dq_i  input  32  split tristate data bus; sram_dq_oe = 1 drives sram_dq_o onto the pins.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS, HOLD; all outputs registered.
REQ-019 IDLE with req=1: latch we/addr/wdata/byte_mask, go to SETUP; req=0: stay IDLE.
REQ-020 SETUP (1 cycle): selected bank cs_n low, sram_addr valid, oe_n/we_n high; -> ACCESS, counter loaded with WAIT_CYCLES-1.
REQ-021 ACCESS (WAIT_CYCLES cycles): read -> oe_n low; write -> we_n low; counter decrements; at counter 0 -> HOLD.
REQ-022 Read data: rdata captured from sram_dq_i on the ACCESS->HOLD edge; held until the next read capture.
REQ-023 HOLD (1 cycle): strobes high, cs_n and sram_addr still valid, ready = 1; -> IDLE unconditionally.
REQ-024 Latency: req accepted at edge 0 -> ready high during cycle WAIT_CYCLES+2; WAIT_CYCLES=2 gives ready in cycle 4.
REQ-025 Back-to-back: req held high is next accepted in the IDLE cycle after HOLD; minimum one IDLE cycle between accesses.
REQ-026 req, we, addr, wdata, byte_mask changes while busy = 1 are ignored.
REQ-027 sram_dq_oe = 1 from SETUP through HOLD on writes only; 0 on reads and in IDLE.
REQ-028 Unselected bank cs_n stays high throughout; never both banks selected.

Reset
REQ-029 rst=1 at any edge forces IDLE regardless of state, including mid-ACCESS.
REQ-030 Reset values: busy=0, ready=0, rdata=0, sram_cs_n=2'b11, sram_oe_n=1, sram_we_n=1, sram_bl_n=4'b1111, sram_addr=0, sram_dq_oe=0, sram_dq_o=0.
REQ-031 An access aborted by reset produces no ready pulse and no rdata update.

Configuration
REQ-032 Macro DMEM_BYTE_LANES_EN defined: writes drive sram_bl_n = ~byte_mask during SETUP..HOLD; reads drive 4'b0000; a write with byte_mask=0 completes the full handshake with we_n never asserted.
REQ-033 Macro undefined: byte_mask ignored; sram_bl_n = 4'b0000 during SETUP..HOLD for every access (full 32-bit words only); 4'b1111 otherwise.

Verification
REQ-034 Reset, then read addr=0x00010, sram_dq_i=0xDEADBEEF -> cs_n=2'b10, oe_n low cycles 2-3, ready in cycle 4, rdata=0xDEADBEEF.
REQ-035 Write addr=0x20004, wdata=0x12345678 -> cs_n=2'b01, sram_addr=0x00004, dq_oe high cycles 1-4, we_n low cycles 2-3, ready cycle 4.
REQ-036 req held high for 3 reads, WAIT_CYCLES=2 -> ready pulses at cycles 4, 9, 14; busy low at cycles 5 and 10.
REQ-037 rst asserted in first ACCESS cycle of a write -> next cycle all strobes high, cs_n=2'b11, no ready, rdata unchanged.
REQ-038 DMEM_BYTE_LANES_EN defined, write byte_mask=4'b0110 -> sram_bl_n=4'b1001; undefined -> 4'b0000.
REQ-039 WAIT_CYCLES=1 read -> oe_n low exactly one cycle, ready in cycle 3.

Source files
------------

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Asynchronous SRAM controller, two 32-bit banks of 2x16-bit chips.
//               Optional byte-lane writes when DMEM_BYTE_LANES_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        byte_mask,
    output logic              busy,
    output logic              ready,
    output logic [31:0]       rdata,
    output logic [1:0]        sram_cs_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_bl_n,
    output logic [ADDR_W-2:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [31:0]       sram_dq_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state, w_state_nx;
    logic [3:0]        r_cnt, w_cnt_nx;
    logic              r_we, r_bank;
    logic              r_busy, r_ready, r_oe_n, r_we_n, r_dq_oe;
    logic [1:0]        r_cs_n;
    logic [3:0]        r_bl_n;
    logic [31:0]       r_rdata, r_dq_o;
    logic [ADDR_W-2:0] r_addr;

    logic              w_acc_we, w_acc_bank, w_active, w_we_ok;
    logic              w_busy_nx, w_ready_nx, w_oe_n_nx, w_we_n_nx, w_dq_oe_nx;
    logic [1:0]        w_cs_n_nx;
    logic [3:0]        w_bl_n_nx;
    logic              w_accept, w_capture;

`ifdef DMEM_BYTE_LANES_EN
    logic [3:0]        r_mask;
    logic [3:0]        w_acc_mask;
`else
    logic              w_unused_mask;
    assign w_unused_mask = ^byte_mask;
`endif

    assign w_accept  = (r_state == S_IDLE) && req;
    assign w_capture = (r_state == S_ACCESS) && (r_cnt == 4'd0) && !r_we;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE:   if (req) w_state_nx = S_SETUP;
            S_SETUP: begin
                w_state_nx = S_ACCESS;
                w_cnt_nx   = c_CNT_LOAD;
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) w_state_nx = S_HOLD;
                else               w_cnt_nx   = r_cnt - 4'd1;
            end
            S_HOLD:   w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered;
        // on the accepting edge the request fields come straight from the inputs.
        w_acc_we   = (r_state == S_IDLE) ? we : r_we;
        w_acc_bank = (r_state == S_IDLE) ? addr[ADDR_W-1] : r_bank;
        w_active   = (w_state_nx != S_IDLE);

`ifdef DMEM_BYTE_LANES_EN
        w_acc_mask = (r_state == S_IDLE) ? byte_mask : r_mask;
        w_we_ok    = |w_acc_mask;
        w_bl_n_nx  = !w_active ? 4'b1111 : (w_acc_we ? ~w_acc_mask : 4'b0000);
`else
        w_we_ok    = 1'b1;
        w_bl_n_nx  = w_active ? 4'b0000 : 4'b1111;
`endif

        w_cs_n_nx = 2'b11;
        if (w_active) w_cs_n_nx[w_acc_bank] = 1'b0;

        w_busy_nx  = w_active;
        w_ready_nx = (w_state_nx == S_HOLD);
        w_oe_n_nx  = !((w_state_nx == S_ACCESS) && !w_acc_we);
        w_we_n_nx  = !((w_state_nx == S_ACCESS) && w_acc_we && w_we_ok);
        w_dq_oe_nx = w_active && w_acc_we;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_bank  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_cs_n  <= 2'b11;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_bl_n  <= 4'b1111;
            r_addr  <= '0;
            r_dq_oe <= 1'b0;
            r_dq_o  <= 32'h0;
`ifdef DMEM_BYTE_LANES_EN
            r_mask  <= 4'h0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_ready <= w_ready_nx;
            r_cs_n  <= w_cs_n_nx;
            r_oe_n  <= w_oe_n_nx;
            r_we_n  <= w_we_n_nx;
            r_bl_n  <= w_bl_n_nx;
            r_dq_oe <= w_dq_oe_nx;
            if (w_accept) begin
                r_we   <= we;
                r_bank <= addr[ADDR_W-1];
                r_addr <= addr[ADDR_W-2:0];
                r_dq_o <= wdata;
`ifdef DMEM_BYTE_LANES_EN
                r_mask <= byte_mask;
`endif
            end
            if (w_capture) r_rdata <= sram_dq_i;
        end
    end

    assign busy       = r_busy;
    assign ready      = r_ready;
    assign rdata      = r_rdata;
    assign sram_cs_n  = r_cs_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;
    assign sram_bl_n  = r_bl_n;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Self-checking bench for sram_ctrl with a behavioural SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;
    localparam int W = 2;
`ifdef DMEM_BYTE_LANES_EN
    localparam bit LANES = 1'b1;
`else
    localparam bit LANES = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, req = 1'b0, we = 1'b0;
    logic [17:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  byte_mask = '0;
    logic        busy, ready, sram_oe_n, sram_we_n, sram_dq_oe;
    logic [31:0] rdata, sram_dq_o;
    logic [31:0] sram_dq_i = '0;
    logic [1:0]  sram_cs_n;
    logic [3:0]  sram_bl_n;
    logic [16:0] sram_addr;

    logic        busy1, ready1, oe_n1, we_n1, dq_oe1;
    logic [31:0] rdata1, dq_o1;
    logic [31:0] dq_i1 = '0;
    logic [1:0]  cs_n1;
    logic [3:0]  bl_n1;
    logic [16:0] addr1;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_mem [logic [17:0]];
    logic [31:0] devmem  [logic [17:0]];
    logic [31:0] exp_rdata;

    sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(18)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .byte_mask(byte_mask), .busy(busy), .ready(ready), .rdata(rdata),
        .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_bl_n(sram_bl_n), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
        .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
    );

    sram_ctrl #(.WAIT_CYCLES(1), .ADDR_W(18)) dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .byte_mask(byte_mask), .busy(busy1), .ready(ready1), .rdata(rdata1),
        .sram_cs_n(cs_n1), .sram_oe_n(oe_n1), .sram_we_n(we_n1),
        .sram_bl_n(bl_n1), .sram_addr(addr1), .sram_dq_o(dq_o1),
        .sram_dq_oe(dq_oe1), .sram_dq_i(dq_i1)
    );

    // Pin-level SRAM: stores bytes whose lanes are enabled while we_n is low.
    always @(negedge clk) begin : dev_model
        logic [17:0] k;
        logic [31:0] v;
        k = {sram_cs_n == 2'b01, sram_addr};
        v = devmem.exists(k) ? devmem[k] : 32'h0;
        if (!sram_we_n && sram_cs_n != 2'b11) begin
            for (int b = 0; b < 4; b++)
                if (!sram_bl_n[b]) v[8*b +: 8] = sram_dq_o[8*b +: 8];
            devmem[k] = v;
        end
        sram_dq_i = (!sram_oe_n && sram_cs_n != 2'b11) ? v : $urandom;
    end

    function automatic logic [31:0] mem_rd(input logic [17:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (!LANES || m[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Called at a falling edge while idle; returns just after the accepting edge
    // with the request fields scrambled so later changes are seen to be ignored.
    task automatic issue(input logic w, input logic [17:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        req = 1'b1; we = w; addr = a; wdata = d; byte_mask = m;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'($urandom_range(0, 1)); addr = 18'($urandom);
        wdata = $urandom; byte_mask = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ready, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_bl_n} !== 11'b00_11_1_1_0_1111) begin
            failures++;
            $display("FAIL reset_ctl got=%b want=%b",
                     {busy, ready, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_bl_n}, 11'b00111101111);
        end
        checks++;
        if (rdata !== 32'h0 || sram_addr !== 17'h0 || sram_dq_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got rdata=%h addr=%h dq_o=%h want zeros", rdata, sram_addr, sram_dq_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sram_cs_n !== 2'b11) begin
            failures++;
            $display("FAIL reset_idle got busy=%b cs_n=%b want 0/11", busy, sram_cs_n);
        end
    endtask

    task automatic test_read;
        devmem[18'h00010] = 32'hDEADBEEF;
        exp_mem[18'h00010] = 32'hDEADBEEF;
        issue(1'b0, 18'h00010, 32'h0, 4'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (sram_cs_n !== ((k <= 4) ? 2'b10 : 2'b11)) begin
                failures++;
                $display("FAIL read_cs k=%0d got=%b want=%b", k, sram_cs_n, (k <= 4) ? 2'b10 : 2'b11);
            end
            checks++;
            if (sram_oe_n !== !(k == 2 || k == 3)) begin
                failures++;
                $display("FAIL read_oe k=%0d got=%b want=%b", k, sram_oe_n, !(k == 2 || k == 3));
            end
            checks++;
            if (ready !== (k == 4)) begin
                failures++;
                $display("FAIL read_ready k=%0d got=%b want=%b", k, ready, (k == 4));
            end
        end
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL read_data got=%h want=deadbeef", rdata);
        end
    endtask

    task automatic test_write;
        issue(1'b1, 18'h20004, 32'h12345678, 4'hF);
        exp_mem[18'h20004] = merge(mem_rd(18'h20004), 32'h12345678, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (sram_cs_n !== ((k <= 4) ? 2'b01 : 2'b11) || sram_dq_oe !== (k <= 4)) begin
                failures++;
                $display("FAIL write_cs_oe k=%0d got cs_n=%b dq_oe=%b want cs_n=%b dq_oe=%b",
                         k, sram_cs_n, sram_dq_oe, (k <= 4) ? 2'b01 : 2'b11, (k <= 4));
            end
            checks++;
            if (sram_we_n !== !(k == 2 || k == 3) || ready !== (k == 4)) begin
                failures++;
                $display("FAIL write_we_rdy k=%0d got we_n=%b ready=%b want we_n=%b ready=%b",
                         k, sram_we_n, ready, !(k == 2 || k == 3), (k == 4));
            end
            if (k <= 4) begin
                checks++;
                if (sram_addr !== 17'h00004 || sram_dq_o !== 32'h12345678) begin
                    failures++;
                    $display("FAIL write_addr_data k=%0d got addr=%h dq=%h want 00004/12345678",
                             k, sram_addr, sram_dq_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        req = 1'b1; we = 1'b0; addr = 18'h00010; wdata = 32'h0; byte_mask = 4'h0;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 14) req = 1'b0;
            checks++;
            if (busy !== !(c == 5 || c == 10 || c == 15) || ready !== (c == 4 || c == 9 || c == 14)) begin
                failures++;
                $display("FAIL b2b c=%0d got busy=%b ready=%b want busy=%b ready=%b", c, busy, ready,
                         !(c == 5 || c == 10 || c == 15), (c == 4 || c == 9 || c == 14));
            end
            if (c == 14) begin
                checks++;
                if (rdata !== mem_rd(18'h00010)) begin
                    failures++;
                    $display("FAIL b2b_data got=%h want=%h", rdata, mem_rd(18'h00010));
                end
            end
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d;
        int we_low;
        d = $urandom;
        issue(1'b1, 18'h20005, d, 4'b0110);
        exp_mem[18'h20005] = merge(mem_rd(18'h20005), d, 4'b0110);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (sram_bl_n !== ((k > 4) ? 4'b1111 : (LANES ? 4'b1001 : 4'b0000))) begin
                failures++;
                $display("FAIL lanes_bl k=%0d got=%b want=%b", k, sram_bl_n,
                         (k > 4) ? 4'b1111 : (LANES ? 4'b1001 : 4'b0000));
            end
        end
        d = $urandom;
        we_low = 0;
        issue(1'b1, 18'h00006, d, 4'b0000);
        exp_mem[18'h00006] = merge(mem_rd(18'h00006), d, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (!sram_we_n) we_low++;
            checks++;
            if (ready !== (k == 4)) begin
                failures++;
                $display("FAIL lanes_zero_ready k=%0d got=%b want=%b", k, ready, (k == 4));
            end
        end
        checks++;
        if (we_low != (LANES ? 0 : 2)) begin
            failures++;
            $display("FAIL lanes_zero_we got=%0d cycles want=%0d", we_low, LANES ? 0 : 2);
        end
    endtask

    task automatic test_reset_abort;
        logic saw_ready;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 18'h20100, $urandom, 4'hF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, ready, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe} !== 7'b00_11_1_1_0) begin
            failures++;
            $display("FAIL abort_wr got=%b want=0011110",
                     {busy, ready, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe});
        end
        saw_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            saw_ready = saw_ready | ready;
        end
        checks++;
        if (saw_ready !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL abort_wr_after got ready_seen=%b rdata=%h want 0/0", saw_ready, rdata);
        end
        devmem[18'h00101] = 32'hCAFEF00D;
        issue(1'b0, 18'h00101, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL abort_rd got ready=%b busy=%b rdata=%h want 0/0/0", ready, busy, rdata);
        end
    endtask

    task automatic test_wait1;
        logic [31:0] v;
        int oe_low;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v = $urandom;
        dq_i1 = v;
        oe_low = 0;
        issue(1'b0, 18'h00007, 32'h0, 4'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (!oe_n1) oe_low++;
            checks++;
            if (ready1 !== (k == 3) || busy1 !== (k <= 3) || oe_n1 !== !(k == 2)) begin
                failures++;
                $display("FAIL wait1 k=%0d got ready=%b busy=%b oe_n=%b want %b/%b/%b", k,
                         ready1, busy1, oe_n1, (k == 3), (k <= 3), !(k == 2));
            end
            if (k == 3) begin
                checks++;
                if (rdata1 !== v) begin
                    failures++;
                    $display("FAIL wait1_data got=%h want=%h", rdata1, v);
                end
            end
        end
        checks++;
        if (oe_low != 1) begin
            failures++;
            $display("FAIL wait1_oe_len got=%0d want=1", oe_low);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic        w;
        logic [17:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [10:0] act, exp;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'h0;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom_range(0, 1));
            a = {1'($urandom_range(0, 1)), 14'h0, 3'($urandom_range(0, 7))};
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            if (!w) exp_rdata = mem_rd(a);
            issue(w, a, d, m);
            if (w) exp_mem[a] = merge(mem_rd(a), d, m);
            for (int k = 1; k <= W + 3; k++) begin
                @(negedge clk);
                if (k == 1) req = 1'($urandom_range(0, 1));
                if (k == W + 2) req = 1'b0;
                act = {busy, ready, sram_cs_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_bl_n};
                if (k <= W + 2)
                    exp = {1'b1, (k == W + 2), (a[17] ? 2'b01 : 2'b10),
                           !(!w && k >= 2 && k <= W + 1),
                           !(w && (!LANES || m != 4'h0) && k >= 2 && k <= W + 1),
                           w, ((LANES && w) ? ~m : 4'b0000)};
                else
                    exp = 11'b00_11_1_1_0_1111;
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL rand_ctl n=%0d k=%0d got=%b want=%b", n, k, act, exp);
                end
                if (k <= W + 2) begin
                    checks++;
                    if (sram_addr !== a[16:0] || (w && sram_dq_o !== d)) begin
                        failures++;
                        $display("FAIL rand_addr_dq n=%0d k=%0d got addr=%h dq=%h want addr=%h dq=%h",
                                 n, k, sram_addr, sram_dq_o, a[16:0], d);
                    end
                end
                if (k >= W + 2) begin
                    checks++;
                    if (rdata !== exp_rdata) begin
                        failures++;
                        $display("FAIL rand_rdata n=%0d k=%0d got=%h want=%h", n, k, rdata, exp_rdata);
                    end
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_byte_lanes();
        test_reset_abort();
        test_wait1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
